// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller.
//   - Register offsets relative to the block base address.
//   - CTRL and INSVC bit positions.
//   - Source index width (enough for up to 32 sources).
//   - Encodings for the request/service FSM states.
package intr_pkg;

  localparam int OFF_PENDING = 'h0;
  localparam int OFF_ENABLE  = 'h4;
  localparam int OFF_CTRL    = 'h8;
  localparam int OFF_INSVC   = 'hC;

  localparam int CTRL_GIE_BIT    = 0;
  localparam int INSVC_VALID_BIT = 31;

  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } intrState_t;

endpackage

// File: rtl/intr_ctrl_prio.sv
// PriorityEncoder: returns the lowest-index set bit of req.
// Ports:
//   req   - request vector, NUM_SRC bits
//   index - index of the lowest set bit (0 when none is set)
//   valid - high when any bit of req is set
module PriorityEncoder
  import intr_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [IDX_W-1:0]   index,
  output logic               valid
);

  // Scan from the top so the last assignment is the lowest set bit.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: memory-mapped interrupt controller with edge/level sources,
// a lowest-index-first arbiter and a single (non-nested) service slot.
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous active-low reset
//   src        - interrupt sources (synchronous to clk)
//   memAddrBus - CPU bus address
//   weBus      - CPU write strobe
//   reBus      - CPU read strobe
//   dataBusOut - CPU write data
//   dataBusIn  - read data (zero unless reBus and address hit)
//   intaAck    - CPU has vectored to the interrupt (one-cycle pulse)
//   reti       - CPU returned from the interrupt (one-cycle pulse)
//   inta       - interrupt request to the CPU
//   idn        - id of the requesting / in-service source
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int                 DBITS     = 32,
  parameter int                 NUM_SRC   = 8,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}},
  parameter logic [DBITS-1:0]   BASE_ADDR = 32'hF0000100,
  parameter logic [DBITS-1:0]   IDN_BASE  = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic [DBITS-1:0]   memAddrBus,
  input  logic               weBus,
  input  logic               reBus,
  input  logic [DBITS-1:0]   dataBusOut,
  output logic [DBITS-1:0]   dataBusIn,
  input  logic               intaAck,
  input  logic               reti,
  output logic               inta,
  output logic [DBITS-1:0]   idn
);

  logic [NUM_SRC-1:0] srcReg, srcPrevReg;
  logic [NUM_SRC-1:0] pendingReg, pendingNext;
  logic [NUM_SRC-1:0] enableReg;
  logic               gieReg;
  intrState_t         stateReg, stateNext;
  logic [IDX_W-1:0]   curIdxReg;
  logic [DBITS-1:0]   idnReg;

  logic hitPending, hitEnable, hitCtrl, hitInsvc;
  logic ackFire, loadReq;
  logic [NUM_SRC-1:0] riseMask, w1cMask, ackMask, candReq;
  logic [IDX_W-1:0]   candIdx;
  logic               candValid;
  logic [DBITS-1:0]   insvcWord;
  logic               unusedData;

  assign hitPending = (memAddrBus == BASE_ADDR + DBITS'(OFF_PENDING));
  assign hitEnable  = (memAddrBus == BASE_ADDR + DBITS'(OFF_ENABLE));
  assign hitCtrl    = (memAddrBus == BASE_ADDR + DBITS'(OFF_CTRL));
  assign hitInsvc   = (memAddrBus == BASE_ADDR + DBITS'(OFF_INSVC));

  // Only the low NUM_SRC bits (and the GIE bit) of write data are used.
  assign unusedData = ^dataBusOut;

  // Edge detection works on the registered copy of src, which is what
  // gives the two-cycle src -> pending -> inta latency.
  assign riseMask = srcReg & ~srcPrevReg;
  assign ackFire  = (stateReg == REQ) && intaAck;
  assign w1cMask  = (weBus && hitPending) ? dataBusOut[NUM_SRC-1:0] : '0;
  assign ackMask  = ackFire ? (NUM_SRC'(1) << curIdxReg) : '0;

  // Per-source pending logic: edge bits are sticky with set-over-clear
  // priority; level bits just follow the registered source.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : genPending
      if (EDGE_MASK[gi]) begin : genEdge
        assign pendingNext[gi] = riseMask[gi] |
                                 (pendingReg[gi] & ~(w1cMask[gi] | ackMask[gi]));
      end else begin : genLevel
        assign pendingNext[gi] = srcReg[gi];
      end
    end
  endgenerate

  assign candReq = pendingReg & enableReg;

  PriorityEncoder #(
    .NUM_SRC(NUM_SRC)
  ) uPrio (
    .req  (candReq),
    .index(candIdx),
    .valid(candValid)
  );

  // Request FSM. Once in REQ the latched source is committed: masking or
  // clearing it afterwards does not withdraw the request.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (gieReg && candValid) stateNext = REQ;
      REQ:     if (intaAck)             stateNext = SVC;
      SVC:     if (reti)                stateNext = IDLE;
      default:                          stateNext = IDLE;
    endcase
  end

  assign loadReq = (stateReg == IDLE) && (stateNext == REQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      srcReg     <= '0;
      srcPrevReg <= '0;
      pendingReg <= '0;
      enableReg  <= '0;
      gieReg     <= 1'b0;
      stateReg   <= IDLE;
      curIdxReg  <= '0;
      idnReg     <= IDN_BASE;
    end else begin
      srcReg     <= src;
      srcPrevReg <= srcReg;
      pendingReg <= pendingNext;
      stateReg   <= stateNext;
      if (weBus && hitEnable) enableReg <= dataBusOut[NUM_SRC-1:0];
      if (weBus && hitCtrl)   gieReg    <= dataBusOut[CTRL_GIE_BIT];
      if (loadReq) begin
        curIdxReg <= candIdx;
        idnReg    <= IDN_BASE + DBITS'(candIdx);
      end
    end
  end

  // INSVC reports the index only while a source is actually in service.
  always_comb begin
    insvcWord = '0;
    if (stateReg == SVC) begin
      insvcWord[INSVC_VALID_BIT] = 1'b1;
      insvcWord[IDX_W-1:0]       = curIdxReg;
    end
  end

  always_comb begin
    dataBusIn = '0;
    if (reBus) begin
      if (hitPending)     dataBusIn = DBITS'(pendingReg);
      else if (hitEnable) dataBusIn = DBITS'(enableReg);
      else if (hitCtrl)   dataBusIn = DBITS'(gieReg);
      else if (hitInsvc)  dataBusIn = insvcWord;
    end
  end

  assign inta = (stateReg == REQ);
  assign idn  = idnReg;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed testbench for intr_ctrl (source 1 configured as level-triggered).
module tb_intr_ctrl;

  localparam logic [31:0] BASE    = 32'hF0000100;
  localparam logic [31:0] A_PEND  = BASE + 32'h0;
  localparam logic [31:0] A_EN    = BASE + 32'h4;
  localparam logic [31:0] A_CTRL  = BASE + 32'h8;
  localparam logic [31:0] A_INSVC = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  src = '0;
  logic [31:0] memAddrBus = '0;
  logic        weBus = 1'b0;
  logic        reBus = 1'b0;
  logic [31:0] dataBusOut = '0;
  logic [31:0] dataBusIn;
  logic        intaAck = 1'b0;
  logic        reti = 1'b0;
  logic        inta;
  logic [31:0] idn;

  int passCount = 0;
  int checkCount = 0;

  intr_ctrl #(
    .DBITS    (32),
    .NUM_SRC  (8),
    .EDGE_MASK(8'hFD),
    .BASE_ADDR(32'hF0000100),
    .IDN_BASE (32'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src       (src),
    .memAddrBus(memAddrBus),
    .weBus     (weBus),
    .reBus     (reBus),
    .dataBusOut(dataBusOut),
    .dataBusIn (dataBusIn),
    .intaAck   (intaAck),
    .reti      (reti),
    .inta      (inta),
    .idn       (idn)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    memAddrBus = addr;
    dataBusOut = data;
    weBus = 1'b1;
    tick();
    weBus = 1'b0;
    dataBusOut = '0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    memAddrBus = addr;
    reBus = 1'b1;
    #1;
    data = dataBusIn;
    reBus = 1'b0;
  endtask

  task automatic pulseAck();
    intaAck = 1'b1;
    tick();
    intaAck = 1'b0;
  endtask

  task automatic pulseReti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    #3;
    checkCount++;
    if (inta !== 1'b0) $display("FAIL reset_inta: got %0b want 0", inta);
    else passCount++;
    checkCount++;
    if (idn !== 32'h0) $display("FAIL reset_idn: got %h want 00000000", idn);
    else passCount++;
    busRead(A_EN, rd);
    checkCount++;
    if (rd !== 32'h0) $display("FAIL reset_enable: got %h want 00000000", rd);
    else passCount++;
    busRead(A_INSVC, rd);
    checkCount++;
    if (rd !== 32'h0) $display("FAIL reset_insvc: got %h want 00000000", rd);
    else passCount++;
    reset = 1'b1;
    tick();
    busWrite(A_EN, 32'hFF);
    busWrite(A_CTRL, 32'h1);
    busRead(A_CTRL, rd);
    checkCount++;
    if (rd !== 32'h1) $display("FAIL ctrl_readback: got %h want 00000001", rd);
    else passCount++;
    // Unmapped address reads zero.
    busRead(BASE + 32'h10, rd);
    checkCount++;
    if (rd !== 32'h0) $display("FAIL unmapped_read: got %h want 00000000", rd);
    else passCount++;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    src[3] = 1'b1;
    tick();
    checkCount++;
    if (inta !== 1'b0) $display("FAIL basic_early1: inta got %0b want 0", inta);
    else passCount++;
    tick();
    busRead(A_PEND, rd);
    checkCount++;
    if (rd !== 32'h08) $display("FAIL basic_pending: got %h want 00000008", rd);
    else passCount++;
    checkCount++;
    if (inta !== 1'b0) $display("FAIL basic_early2: inta got %0b want 0", inta);
    else passCount++;
    tick();
    checkCount++;
    if (inta !== 1'b1 || idn !== 32'd3) $display("FAIL basic_req: inta=%0b idn=%0d want 1/3", inta, idn);
    else passCount++;
    pulseAck();
    checkCount++;
    if (inta !== 1'b0) $display("FAIL basic_ack_inta: got %0b want 0", inta);
    else passCount++;
    busRead(A_PEND, rd);
    checkCount++;
    if (rd !== 32'h0) $display("FAIL basic_ack_pending: got %h want 00000000", rd);
    else passCount++;
    busRead(A_INSVC, rd);
    checkCount++;
    if (rd !== 32'h80000003) $display("FAIL basic_insvc: got %h want 80000003", rd);
    else passCount++;
    src[3] = 1'b0;
    pulseReti();
    busRead(A_INSVC, rd);
    checkCount++;
    if (rd !== 32'h0) $display("FAIL basic_reti_insvc: got %h want 00000000", rd);
    else passCount++;
    // intaAck while idle is ignored.
    pulseAck();
    busRead(A_INSVC, rd);
    checkCount++;
    if (rd !== 32'h0 || inta !== 1'b0) $display("FAIL stray_ack: insvc=%h inta=%0b want 0/0", rd, inta);
    else passCount++;
    $display("test_basic done");
  endtask

  task automatic test_priority();
    src[5] = 1'b1;
    src[2] = 1'b1;
    tick(); tick(); tick();
    checkCount++;
    if (inta !== 1'b1 || idn !== 32'd2) $display("FAIL prio_first: inta=%0b idn=%0d want 1/2", inta, idn);
    else passCount++;
    // reti while requesting is ignored.
    pulseReti();
    checkCount++;
    if (inta !== 1'b1 || idn !== 32'd2) $display("FAIL prio_stray_reti: inta=%0b idn=%0d want 1/2", inta, idn);
    else passCount++;
    pulseAck();
    pulseReti();
    checkCount++;
    if (inta !== 1'b0) $display("FAIL prio_idle_gap: inta got %0b want 0", inta);
    else passCount++;
    tick();
    checkCount++;
    if (inta !== 1'b1 || idn !== 32'd5) $display("FAIL prio_second: inta=%0b idn=%0d want 1/5", inta, idn);
    else passCount++;
    src[5] = 1'b0;
    src[2] = 1'b0;
    pulseAck();
    pulseReti();
    tick();
    checkCount++;
    if (inta !== 1'b0) $display("FAIL prio_drained: inta got %0b want 0", inta);
    else passCount++;
    $display("test_priority done");
  endtask

  task automatic test_mask();
    logic [31:0] rd;
    src[4] = 1'b1;
    tick(); tick(); tick();
    checkCount++;
    if (inta !== 1'b1 || idn !== 32'd4) $display("FAIL mask_req: inta=%0b idn=%0d want 1/4", inta, idn);
    else passCount++;
    busWrite(A_EN, 32'h0);
    tick();
    checkCount++;
    if (inta !== 1'b1 || idn !== 32'd4) $display("FAIL mask_hold: inta=%0b idn=%0d want 1/4", inta, idn);
    else passCount++;
    pulseAck();
    busRead(A_INSVC, rd);
    checkCount++;
    if (rd !== 32'h80000004 || inta !== 1'b0) $display("FAIL mask_ack: insvc=%h inta=%0b want 80000004/0", rd, inta);
    else passCount++;
    src[4] = 1'b0;
    pulseReti();
    tick();
    checkCount++;
    if (idn !== 32'd4 || inta !== 1'b0) $display("FAIL mask_idle_idn: idn=%0d inta=%0b want 4/0", idn, inta);
    else passCount++;
    busWrite(A_EN, 32'hFF);
    $display("test_mask done");
  endtask

  task automatic test_level();
    logic [31:0] rd;
    src[1] = 1'b1;
    tick(); tick(); tick();
    checkCount++;
    if (inta !== 1'b1 || idn !== 32'd1) $display("FAIL level_req: inta=%0b idn=%0d want 1/1", inta, idn);
    else passCount++;
    pulseAck();
    busWrite(A_PEND, 32'h2);
    busRead(A_PEND, rd);
    checkCount++;
    if (rd !== 32'h2) $display("FAIL level_w1c: pending got %h want 00000002", rd);
    else passCount++;
    pulseReti();
    tick();
    checkCount++;
    if (inta !== 1'b1 || idn !== 32'd1) $display("FAIL level_rereq: inta=%0b idn=%0d want 1/1", inta, idn);
    else passCount++;
    src[1] = 1'b0;
    pulseAck();
    pulseReti();
    tick(); tick();
    checkCount++;
    if (inta !== 1'b0) $display("FAIL level_released: inta got %0b want 0", inta);
    else passCount++;
    $display("test_level done");
  endtask

  task automatic test_same_cycle();
    logic [31:0] rd;
    busWrite(A_CTRL, 32'h0);
    src[0] = 1'b1;
    tick();
    // Pending[0] sets on the next edge, the same edge that takes this W1C.
    busWrite(A_PEND, 32'h1);
    busRead(A_PEND, rd);
    checkCount++;
    if (rd !== 32'h1) $display("FAIL set_wins: pending got %h want 00000001", rd);
    else passCount++;
    busWrite(A_PEND, 32'h1);
    busRead(A_PEND, rd);
    checkCount++;
    if (rd !== 32'h0) $display("FAIL w1c_clear: pending got %h want 00000000", rd);
    else passCount++;
    src[0] = 1'b0;
    busWrite(A_CTRL, 32'h1);
    $display("test_same_cycle done");
  endtask

  task automatic test_reset_svc();
    logic [31:0] rd;
    src[6] = 1'b1;
    tick(); tick(); tick();
    pulseAck();
    busRead(A_INSVC, rd);
    checkCount++;
    if (rd !== 32'h80000006) $display("FAIL rst_pre_insvc: got %h want 80000006", rd);
    else passCount++;
    #1;
    reset = 1'b0;
    #1;
    busRead(A_INSVC, rd);
    checkCount++;
    if (rd !== 32'h0) $display("FAIL rst_async_insvc: got %h want 00000000", rd);
    else passCount++;
    busRead(A_EN, rd);
    checkCount++;
    if (rd !== 32'h0) $display("FAIL rst_async_enable: got %h want 00000000", rd);
    else passCount++;
    checkCount++;
    if (inta !== 1'b0 || idn !== 32'h0) $display("FAIL rst_async_out: inta=%0b idn=%h want 0/00000000", inta, idn);
    else passCount++;
    reset = 1'b1;
    tick(); tick(); tick();
    checkCount++;
    if (inta !== 1'b0) $display("FAIL rst_abandon: inta got %0b want 0", inta);
    else passCount++;
    src[6] = 1'b0;
    $display("test_reset_svc done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_level();
    test_same_cycle();
    test_reset_svc();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter DBITS, default 32: width of data, address and idn buses.
REQ-002 SHALL have parameter NUM_SRC, default 8, legal range 1..32: number of interrupt sources.
REQ-003 SHALL have parameter EDGE_MASK, NUM_SRC bits, default all ones: bit=1 means edge-triggered source, bit=0 means level source.
REQ-004 SHALL have parameter BASE_ADDR, DBITS bits, default 32'hF0000100: register block base address.
REQ-005 SHALL have parameter IDN_BASE, DBITS bits, default 32'h0: idn value reported for source 0.
REQ-006 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port src, input, NUM_SRC: interrupt sources, synchronous to clk.
REQ-009 SHALL have port memAddrBus, input, DBITS: CPU bus address.
REQ-010 SHALL have port weBus, input, 1: CPU bus write strobe.
REQ-011 SHALL have port reBus, input, 1: CPU bus read strobe.
REQ-012 SHALL have port dataBusOut, input, DBITS: CPU write data.
REQ-013 SHALL have port dataBusIn, output, DBITS: read data; zero unless reBus is high and the address hits the block.
REQ-014 SHALL have port intaAck, input, 1: one-cycle pulse when the CPU vectors to the interrupt.
REQ-015 SHALL have port reti, input, 1: one-cycle pulse when the CPU returns from interrupt.
REQ-016 SHALL have port inta, output, 1: interrupt request to the CPU.
REQ-017 SHALL have port idn, output, DBITS: id of the requesting or in-service source.

Function
REQ-018 SHALL define registers: +0x0 PENDING (RO; write-1-to-clear edge bits), +0x4 ENABLE (RW), +0x8 CTRL (bit0 GIE, RW), +0xC INSVC (RO; bit31 valid, low bits source index).
REQ-019 SHALL decode reads combinationally: dataBusIn valid in the same cycle as reBus; register bits above NUM_SRC read zero.
REQ-020 SHALL capture writes on the clk edge on which weBus is high.
REQ-021 SHALL set an edge source pending bit on a 0->1 transition of src sampled across consecutive clk edges; the bit SHALL hold until cleared by a W1C write or by intaAck for that source.
REQ-022 SHALL make a level source pending bit equal the registered src value; a W1C write SHALL have no effect on it.
REQ-023 SHALL compute a candidate as the lowest-index bit of PENDING & ENABLE, qualified by GIE.
REQ-024 SHALL implement an FSM with states IDLE, REQ and SVC.
REQ-025 IDLE->REQ SHALL occur when a candidate exists; the candidate index SHALL be latched; inta=1 from the next cycle.
REQ-026 In REQ, inta=1 and idn=IDN_BASE+latched index SHALL hold stable; masking, disabling or clearing the source SHALL NOT withdraw the request.
REQ-027 REQ->SVC SHALL occur on intaAck; inta=0 on the next cycle; the edge pending bit of the latched source SHALL clear on that edge; INSVC valid=1.
REQ-028 SVC->IDLE SHALL occur on reti; INSVC valid=0; a new request SHALL be raised no earlier than the cycle after IDLE is entered. Interrupts are not nested.
REQ-029 intaAck outside REQ and reti outside SVC SHALL be ignored.
REQ-030 If a source edge and its clearing (W1C or intaAck) fall in the same cycle, set SHALL win.
REQ-031 idn SHALL hold the last latched value in IDLE; it is IDN_BASE after reset.
REQ-032 Request latency SHALL be: src rising at edge N -> pending at N+1 -> inta high after N+2.

Reset
REQ-033 SHALL, while reset=0, asynchronously force: FSM=IDLE, PENDING=0, ENABLE=0, GIE=0, INSVC=0, edge-detect history=0, inta=0, idn=IDN_BASE.
REQ-034 SHALL, on reset assertion in REQ or SVC, abandon the request without an acknowledge.

Structure
REQ-035 SHALL place register offsets, FSM state encodings and the CTRL bit position in the shared intr_pkg package.
REQ-036 SHALL implement lowest-index selection as sub-module PriorityEncoder (NUM_SRC in, index plus valid out).

Verification
REQ-037 SHALL test: ENABLE=0xFF, GIE=1, src[3] rises -> inta=1 with idn=3 two cycles later; intaAck -> inta=0, PENDING[3]=0, INSVC=0x80000003.
REQ-038 SHALL test: src[5] and src[2] rise in the same cycle -> idn=2 first; after reti, idn=5.
REQ-039 SHALL test: in REQ for source 4, write ENABLE=0 -> inta stays 1 and idn stays 4 until intaAck.
REQ-040 SHALL test: EDGE_MASK bit1=0, hold src[1]=1 -> after reti it is re-requested; W1C 0x2 leaves PENDING[1]=1.
REQ-041 SHALL test: src[0] rises in the same cycle as a W1C of bit 0 -> PENDING[0]=1.
REQ-042 SHALL test: reset pulled low in SVC -> inta=0, INSVC=0, ENABLE=0 immediately, without waiting for clk.
